// File: rtl/game_flow_controller_if.sv
`default_nettype none
// ============================================================================
// Module   : game_flow_controller_if
// Brief    : Front-end inputs and player/map/renderer outputs of the
//            game-flow controller, grouped as one bundle.
// Revision : 1.0 - initial release
// ============================================================================
interface game_flow_controller_if #(
  parameter int NUM_LEVELS = 4,
  parameter int LIVES      = 3,
  parameter int LEVEL_TIME = 120
);
  localparam int c_LW = (NUM_LEVELS > 1) ? $clog2(NUM_LEVELS) : 1;
  localparam int c_HW = $clog2(LIVES + 1);
  localparam int c_TW = $clog2(LEVEL_TIME + 1);

  logic            frame_tick;
  logic            start_btn;
  logic            pause_btn;
  logic            gameover;
  logic            gamewin;
  logic            revive;
  logic [c_LW-1:0] level;
  logic [c_HW-1:0] lives_left;
  logic [c_TW-1:0] time_left;
  logic [2:0]      screen;
  logic            play_active;

  modport master (
    output frame_tick, start_btn, pause_btn, gameover, gamewin,
    input  revive, level, lives_left, time_left, screen, play_active
  );

  modport slave (
    input  frame_tick, start_btn, pause_btn, gameover, gamewin,
    output revive, level, lives_left, time_left, screen, play_active
  );
endinterface
`default_nettype wire

// File: rtl/game_flow_controller.sv
`default_nettype none
// ============================================================================
// Module   : game_flow_controller
// Brief    : Menu/load/play/pause/death/clear/over/win sequencer with lives,
//            level index and optional per-level countdown (GAME_TIMER_EN).
// Revision : 1.0 - initial release
// ============================================================================
module game_flow_controller #(
  parameter int NUM_LEVELS   = 4,
  parameter int LIVES        = 3,
  parameter int DEATH_FRAMES = 60,
  parameter int LEVEL_TIME   = 120
) (
  input  logic                  Clk,
  input  logic                  Reset_n,
  game_flow_controller_if.slave bus
);
  localparam int c_LW = (NUM_LEVELS > 1) ? $clog2(NUM_LEVELS) : 1;
  localparam int c_HW = $clog2(LIVES + 1);
  localparam int c_TW = $clog2(LEVEL_TIME + 1);
  localparam int c_DW = (DEATH_FRAMES > 1) ? $clog2(DEATH_FRAMES) : 1;

  localparam logic [c_LW-1:0] c_LAST_LEVEL = c_LW'(NUM_LEVELS - 1);
  localparam logic [c_LW-1:0] c_LEVEL_ONE  = c_LW'(1);
  localparam logic [c_HW-1:0] c_LIVES_INIT = c_HW'(LIVES);
  localparam logic [c_HW-1:0] c_ONE_LIFE   = c_HW'(1);
  localparam logic [c_DW-1:0] c_DEATH_LAST = c_DW'(DEATH_FRAMES - 1);
  localparam logic [c_DW-1:0] c_DEATH_ONE  = c_DW'(1);

  typedef enum logic [2:0] {
    ST_MENU  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_PLAY  = 3'd2,
    ST_PAUSE = 3'd3,
    ST_DEATH = 3'd4,
    ST_CLEAR = 3'd5,
    ST_OVER  = 3'd6,
    ST_WIN   = 3'd7
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [c_LW-1:0] r_level;
  logic [c_LW-1:0] w_level_nxt;
  logic [c_HW-1:0] r_lives;
  logic [c_HW-1:0] w_lives_nxt;
  logic [c_DW-1:0] r_death_cnt;
  logic [c_DW-1:0] w_death_cnt_nxt;
  logic            r_start_prev;
  logic            r_pause_prev;
  logic            r_start_arm;
  logic            r_pause_arm;
  logic            w_start_e;
  logic            w_pause_e;
  logic            w_time_zero;

  // A button held through reset release must be let go before it can count.
  assign w_start_e = bus.start_btn & ~r_start_prev & r_start_arm;
  assign w_pause_e = bus.pause_btn & ~r_pause_prev & r_pause_arm;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_start_prev <= 1'b0;
      r_pause_prev <= 1'b0;
      r_start_arm  <= 1'b0;
      r_pause_arm  <= 1'b0;
    end else begin
      r_start_prev <= bus.start_btn;
      r_pause_prev <= bus.pause_btn;
      r_start_arm  <= r_start_arm | ~bus.start_btn;
      r_pause_arm  <= r_pause_arm | ~bus.pause_btn;
    end
  end

`ifdef GAME_TIMER_EN
  localparam logic [c_TW-1:0] c_TIME_INIT = c_TW'(LEVEL_TIME);
  localparam logic [c_TW-1:0] c_TIME_ONE  = c_TW'(1);

  logic [c_TW-1:0] r_time;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_time <= '0;
    end else if (r_state == ST_LOAD) begin
      r_time <= c_TIME_INIT;
    end else if (r_state == ST_PLAY && bus.frame_tick && r_time != '0) begin
      r_time <= r_time - c_TIME_ONE;
    end
  end

  assign w_time_zero   = (r_time == '0);
  assign bus.time_left = r_time;
`else
  assign w_time_zero   = 1'b0;
  assign bus.time_left = {c_TW{1'b0}};
`endif

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state     <= ST_MENU;
      r_level     <= '0;
      r_lives     <= c_LIVES_INIT;
      r_death_cnt <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_level     <= w_level_nxt;
      r_lives     <= w_lives_nxt;
      r_death_cnt <= w_death_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_level_nxt     = r_level;
    w_lives_nxt     = r_lives;
    w_death_cnt_nxt = r_death_cnt;
    case (r_state)
      ST_MENU: begin
        if (w_start_e) begin
          w_level_nxt = '0;
          w_lives_nxt = c_LIVES_INIT;
          w_state_nxt = ST_LOAD;
        end
      end
      ST_LOAD: begin
        w_death_cnt_nxt = '0;
        w_state_nxt     = ST_PLAY;
      end
      ST_PLAY: begin
        // Death outranks a simultaneous win.
        if (bus.gameover || w_time_zero) begin
          if (r_lives != '0) begin
            w_lives_nxt = r_lives - c_ONE_LIFE;
          end
          w_state_nxt = (r_lives <= c_ONE_LIFE) ? ST_OVER : ST_DEATH;
        end else if (bus.gamewin) begin
          w_state_nxt = (r_level >= c_LAST_LEVEL) ? ST_WIN : ST_CLEAR;
        end else if (w_pause_e) begin
          w_state_nxt = ST_PAUSE;
        end
      end
      ST_PAUSE: begin
        if (w_pause_e) begin
          w_state_nxt = ST_PLAY;
        end
      end
      ST_DEATH: begin
        if (bus.frame_tick) begin
          if (r_death_cnt >= c_DEATH_LAST) begin
            w_death_cnt_nxt = '0;
            w_state_nxt     = ST_LOAD;
          end else begin
            w_death_cnt_nxt = r_death_cnt + c_DEATH_ONE;
          end
        end
      end
      ST_CLEAR: begin
        if (w_start_e) begin
          if (r_level < c_LAST_LEVEL) begin
            w_level_nxt = r_level + c_LEVEL_ONE;
          end
          w_state_nxt = ST_LOAD;
        end
      end
      ST_OVER, ST_WIN: begin
        if (w_start_e) begin
          w_state_nxt = ST_MENU;
        end
      end
      default: begin
        w_state_nxt = ST_MENU;
      end
    endcase
  end

  assign bus.screen      = r_state;
  assign bus.revive      = (r_state == ST_LOAD);
  assign bus.play_active = (r_state == ST_PLAY);
  assign bus.level       = r_level;
  assign bus.lives_left  = r_lives;
endmodule
`default_nettype wire
